// File: rtl/prbs_source_pkg.sv
// Shared PRBS9 constants, seed helpers and BER checker constants.
// PRBS source and BER checker both import this package.
package prbs_source_pkg;
  localparam int PRBS_W = 9;
  localparam int PRBS_SEQ_LEN = 511;
  localparam int TAP_A = 8;
  localparam int TAP_B = 4;
  localparam int INJ_W = 16;
  localparam int BER_REG_W = 32;
  localparam int BER_SEQ_LEN = PRBS_SEQ_LEN;

  typedef logic [PRBS_W-1:0] prbs_t;

  localparam prbs_t PRBS_DEF_SEED = 9'h1FF;
  localparam prbs_t LOCK_SEED = 9'h1FF;

  // x^9 + x^5 + 1, Fibonacci form
  function automatic prbs_t prbs9_step(prbs_t r);
    return {r[PRBS_W-2:0], r[TAP_A] ^ r[TAP_B]};
  endfunction

  function automatic prbs_t seed_guard(prbs_t s);
    return (s == '0) ? LOCK_SEED : s;
  endfunction
endpackage

// File: rtl/prbs9_lfsr.sv
// PRBS9 shift register: seeded on reset or load,
// advances one step per emitted bit.
module prbs9_lfsr
  import prbs_source_pkg::*;
#(
  parameter prbs_t SEED_RST = PRBS_DEF_SEED
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load_i,
  input  prbs_t seed_i,
  input  logic  adv_i,
  output logic  out_o
);
  prbs_t r_q, r_d;

  always_comb begin
    r_d = r_q;
    unique case (1'b1)
      load_i:  r_d = seed_guard(seed_i);
      adv_i:   r_d = prbs9_step(r_q);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= SEED_RST;
    else        r_q <= r_d;
  end

  assign out_o = r_q[TAP_A];
endmodule

// File: rtl/prbs_source.sv
// Oversampled PRBS9 bit source with period marker and
// single-bit error injection for BER checker exercise.
module prbs_source
  import prbs_source_pkg::*;
#(
  parameter int    SEQ_LEN   = PRBS_SEQ_LEN,
  parameter int    OS_FACTOR = 4,
  parameter prbs_t DEF_SEED  = PRBS_DEF_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              load,
  input  logic [PRBS_W-1:0] seed_in,
  input  logic              inject_err,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              seq_start,
  output logic [INJ_W-1:0]  inj_count
);
  localparam int DIV_W = $clog2(OS_FACTOR);
  localparam int PH_W = $clog2(SEQ_LEN);
  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(OS_FACTOR - 1);
  localparam logic [PH_W-1:0] PH_LAST =
    PH_W'(SEQ_LEN - 1);
  localparam logic [INJ_W-1:0] INJ_MAX = '1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [INJ_W-1:0] cnt_q, cnt_d;
  logic pend_q, pend_d;
  logic bit_q, bit_d;
  logic vld_q, vld_d;
  logic sos_q, sos_d;
  logic emit, step, lfsr_bit;

  // Load wins over enable, so the three cases stay exclusive
  assign emit = enable & ~load & (div_q == DIV_LAST);
  assign step = enable & ~load & ~emit;

  prbs9_lfsr #(
    .SEED_RST(DEF_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst),
    .load_i(load),
    .seed_i(seed_in),
    .adv_i (emit),
    .out_o (lfsr_bit)
  );

  always_comb begin
    div_d  = div_q;
    ph_d   = ph_q;
    cnt_d  = cnt_q;
    pend_d = pend_q | inject_err;
    bit_d  = bit_q;
    vld_d  = 1'b0;
    sos_d  = 1'b0;
    unique case (1'b1)
      load: begin
        div_d  = '0;
        ph_d   = '0;
        pend_d = 1'b0;
      end
      emit: begin
        div_d  = '0;
        ph_d   = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
        // a pulse on this edge targets the next bit
        pend_d = inject_err;
        bit_d  = lfsr_bit ^ pend_q;
        vld_d  = 1'b1;
        sos_d  = (ph_q == '0);
        if (pend_q && cnt_q != INJ_MAX)
          cnt_d = cnt_q + 1'b1;
      end
      step:    div_d = div_q + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= '0;
      ph_q   <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      bit_q  <= 1'b0;
      vld_q  <= 1'b0;
      sos_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      ph_q   <= ph_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      bit_q  <= bit_d;
      vld_q  <= vld_d;
      sos_q  <= sos_d;
    end
  end

  assign bit_out   = bit_q;
  assign bit_valid = vld_q;
  assign seq_start = sos_q;
  assign inj_count = cnt_q;
endmodule

// File: doc/prbs_source.md
PRBS_SOURCE -- requirements
Module: prbs_source

Interface
REQ-001 SHALL have parameter SEQ_LEN, 511, PRBS period in bits (PRBS9 only).
REQ-002 SHALL have parameter OS_FACTOR, 4, clock cycles per emitted bit (>=2).
REQ-003 SHALL have parameter DEF_SEED, 9'h1FF, seed applied at reset.
REQ-004 SHALL use one clock and an asynchronous active-low reset: clk  in  1  system clock.
REQ-005 rst  in  1  asynchronous reset, active low.
REQ-006 enable  in  1  run gate; 0 freezes divider, LFSR, phase and outputs except bit_valid.
REQ-007 load  in  1  single-cycle seed load request.
REQ-008 seed_in  in  9  seed value captured on load.
REQ-009 inject_err  in  1  pulse requesting inversion of one future emitted bit.
REQ-010 bit_out  out  1  emitted PRBS bit (sx to the BER checker).
REQ-011 bit_valid  out  1  one-cycle strobe qualifying bit_out (enable of the BER checker).
REQ-012 seq_start  out  1  high with bit_valid on the first bit of each period.
REQ-013 inj_count  out  16  number of bits inverted since reset, saturating.

Function
REQ-014 LFSR SHALL be 9-bit r, polynomial x^9+x^5+1: output bit r[8], feedback fb=r[8]^r[4], update r<={r[7:0],fb}.
REQ-015 Divider SHALL count 0..OS_FACTOR-1 while enable=1 and wrap to 0; its value SHALL hold while enable=0.
REQ-016 Emission: on the edge where enable=1 and divider=OS_FACTOR-1, bit_out<=r[8]^pending, bit_valid<=1, LFSR advances, phase advances.
REQ-017 bit_valid SHALL be 0 on all other edges; bit_out SHALL hold its last value between emissions.
REQ-018 Latency: first bit_valid SHALL appear OS_FACTOR cycles after the first enable=1 cycle following reset or load.
REQ-019 Phase counter SHALL count 0..SEQ_LEN-1 per emission and wrap to 0; seq_start<=1 on an emission with phase=0, else 0.
REQ-020 inject_err=1 SHALL set pending; pending SHALL clear on the emission that consumes it.
REQ-021 inject_err asserted in the same cycle as an emission SHALL affect the following emission, not the current one.
REQ-022 Multiple inject_err pulses before one emission SHALL invert only one bit.
REQ-023 inj_count SHALL increment by 1 per inverted bit and saturate at 16'hFFFF.
REQ-024 load=1 SHALL set r<=seed_in, or 9'h1FF if seed_in=0 (lock-up guard), and zero divider, phase and pending.
REQ-025 load SHALL have priority over enable; no emission on a load cycle.
REQ-026 load SHALL NOT clear inj_count.
REQ-027 A load or reset during an emission cycle SHALL abort that emission.

Reset
REQ-028 rst=0 SHALL immediately force r=DEF_SEED, divider=0, phase=0, pending=0, bit_out=0, bit_valid=0, seq_start=0, inj_count=0.
REQ-029 Reset release SHALL be treated as synchronous to clk; the first emission follows REQ-018.

Structure
REQ-030 SEQ_LEN, PRBS width (9), tap positions, DEF_SEED and counter widths SHALL live in a shared package with the BER checker constants (SEQ_LEN=511, 32-bit register width).
REQ-031 Phase width SHALL be $clog2(SEQ_LEN); divider width SHALL be $clog2(OS_FACTOR).
REQ-032 One sub-module, prbs9_lfsr (state, advance, load, out), SHALL be instantiated; the divider, phase, injection and counting logic SHALL stay in prbs_source.

Verification
REQ-033 Reset, enable=1, OS_FACTOR=4 -> first bit_valid at cycle 4; bits 1..9 = 1, bit 10 = 0; seq_start on bit 1 only.
REQ-034 Run 2*511 emissions -> seq_start on bits 1 and 512; bits 512..1022 equal bits 1..511; 256 ones per period.
REQ-035 Toggle enable low for 7 cycles mid-run -> no bit_valid during the gap; the bit sequence is unchanged, only delayed by 7 cycles.
REQ-036 load seed_in=0 -> sequence identical to DEF_SEED 9'h1FF; load seed_in=9'h001 -> bits 1..8 = 0, bit 9 = 1.
REQ-037 inject_err in an emission cycle, then a second pulse before the next emission -> exactly one later bit inverted, inj_count=1; chained into the BER checker, error_flag rises.
REQ-038 Assert rst low mid-run with pending=1 -> all outputs 0 asynchronously; after release the sequence restarts from bit 1 with no inversion.
